// File: rtl/usb_line_ctrl_if.sv
// Bus-side signal bundle of usb_line_ctrl: PHY receive/transmit lines and the
// packet-transmitter arbitration handshake.
interface usb_line_ctrl_if;
  logic phy_rx_dp;
  logic phy_rx_dn;
  logic phy_rx_chg;
  logic phy_tx_dp;
  logic phy_tx_dn;
  logic phy_tx_en;
  logic pkt_tx_req;
  logic pkt_tx_gnt;
  logic pkt_tx_dp;
  logic pkt_tx_dn;
  logic pkt_tx_en;

  modport master (
    input  phy_rx_dp, phy_rx_dn, phy_rx_chg,
    input  pkt_tx_req, pkt_tx_dp, pkt_tx_dn, pkt_tx_en,
    output phy_tx_dp, phy_tx_dn, phy_tx_en, pkt_tx_gnt
  );

  modport slave (
    output phy_rx_dp, phy_rx_dn, phy_rx_chg,
    output pkt_tx_req, pkt_tx_dp, pkt_tx_dn, pkt_tx_en,
    input  phy_tx_dp, phy_tx_dn, phy_tx_en, pkt_tx_gnt
  );
endinterface

// File: rtl/usb_line_ctrl.sv
// Full-speed USB bus-level controller: line-state decode, bus reset / suspend /
// resume detection, remote-wakeup K generation and PHY TX arbitration.
module usb_line_ctrl #(
  parameter int RST_DET_CYCLES = 120,
  parameter int SUSPEND_CYCLES = 144000,
  parameter int WAKE_CYCLES    = 96000,
  parameter int TIMER_W        = 18
) (
  input  logic            clk,
  input  logic            rst,
  usb_line_ctrl_if.master bus,
  input  logic            wake_req_i,
  output logic            ls_j_o,
  output logic            ls_k_o,
  output logic            ls_se0_o,
  output logic            bus_reset_o,
  output logic            suspended_o,
  output logic            evt_reset_o,
  output logic            evt_suspend_o,
  output logic            evt_resume_o
);

  typedef enum logic [2:0] {
    S_ACTIVE,
    S_BUS_RST,
    S_SUSP,
    S_WAKE,
    S_RESUME
  } state_e;

  localparam logic [TIMER_W-1:0] CNT_MAX   = '1;
  localparam logic [TIMER_W-1:0] CNT_ONE   = TIMER_W'(1);
  localparam logic [TIMER_W-1:0] RST_LAST  = TIMER_W'(RST_DET_CYCLES - 1);
  localparam logic [TIMER_W-1:0] SUSP_LAST = TIMER_W'(SUSPEND_CYCLES - 1);
  localparam logic [TIMER_W-1:0] WAKE_LAST = TIMER_W'(WAKE_CYCLES - 1);

  state_e             state_q, state_d;
  logic               ls_j_q, ls_k_q, ls_se0_q;
  logic [TIMER_W-1:0] se0_cnt_q, se0_cnt_d;
  logic [TIMER_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [TIMER_W-1:0] wake_cnt_q, wake_cnt_d;
  logic               gnt_q, gnt_d;
  logic               evt_reset_q, evt_reset_d;
  logic               evt_suspend_q, evt_suspend_d;
  logic               evt_resume_q, evt_resume_d;

  logic raw_k;
  logic se0_run, idle_run, se0_hit, idle_hit;
  logic tx_dp, tx_dn, tx_en;

  assign raw_k = ~bus.phy_rx_dp & bus.phy_rx_dn;

  // Our own transmission (packet EOP, wakeup K) must never look like host activity.
  assign se0_run  = ls_se0_q & ~tx_en;
  assign idle_run = ls_j_q & ~bus.phy_rx_chg & ~tx_en & ~gnt_q;
  assign se0_hit  = se0_run & (se0_cnt_q == RST_LAST);
  assign idle_hit = idle_run & (idle_cnt_q == SUSP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_ACTIVE;
      ls_j_q        <= 1'b0;
      ls_k_q        <= 1'b0;
      ls_se0_q      <= 1'b0;
      se0_cnt_q     <= '0;
      idle_cnt_q    <= '0;
      wake_cnt_q    <= '0;
      gnt_q         <= 1'b0;
      evt_reset_q   <= 1'b0;
      evt_suspend_q <= 1'b0;
      evt_resume_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      ls_j_q        <= bus.phy_rx_dp & ~bus.phy_rx_dn;
      ls_k_q        <= raw_k;
      ls_se0_q      <= ~bus.phy_rx_dp & ~bus.phy_rx_dn;
      se0_cnt_q     <= se0_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      wake_cnt_q    <= wake_cnt_d;
      gnt_q         <= gnt_d;
      evt_reset_q   <= evt_reset_d;
      evt_suspend_q <= evt_suspend_d;
      evt_resume_q  <= evt_resume_d;
    end
  end

  always_comb begin
    se0_cnt_d  = '0;
    idle_cnt_d = '0;
    if (se0_run) begin
      se0_cnt_d = (se0_cnt_q == CNT_MAX) ? se0_cnt_q : se0_cnt_q + CNT_ONE;
    end
    if (idle_run) begin
      idle_cnt_d = (idle_cnt_q == CNT_MAX) ? idle_cnt_q : idle_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    if ((state_q != S_WAKE) && se0_hit) begin
      state_d = S_BUS_RST;
    end else begin
      case (state_q)
        S_BUS_RST: if (!ls_se0_q) state_d = S_ACTIVE;
        S_ACTIVE:  if (idle_hit) state_d = S_SUSP;
        S_SUSP: begin
          // A K already on the wire beats a same-cycle wakeup request.
          if (ls_k_q) begin
            state_d = S_RESUME;
          end else if (wake_req_i && !raw_k) begin
            state_d    = S_WAKE;
            wake_cnt_d = WAKE_LAST;
          end
        end
        S_WAKE: begin
          if (wake_cnt_q == '0) state_d = S_RESUME;
          else                  wake_cnt_d = wake_cnt_q - CNT_ONE;
        end
        S_RESUME:  if (!ls_k_q) state_d = S_ACTIVE;
        default:   state_d = S_ACTIVE;
      endcase
    end
    gnt_d         = bus.pkt_tx_req && (state_d == S_ACTIVE);
    evt_reset_d   = (state_d == S_BUS_RST) && (state_q != S_BUS_RST);
    evt_suspend_d = (state_q == S_ACTIVE) && (state_d == S_SUSP);
    evt_resume_d  = (state_q == S_RESUME) && (state_d == S_ACTIVE);
  end

  always_comb begin
    tx_dp = 1'b0;
    tx_dn = 1'b0;
    tx_en = 1'b0;
    if (gnt_q) begin
      tx_dp = bus.pkt_tx_dp;
      tx_dn = bus.pkt_tx_dn;
      tx_en = bus.pkt_tx_en;
    end else if (state_q == S_WAKE) begin
      tx_dp = 1'b0;
      tx_dn = 1'b1;
      tx_en = 1'b1;
    end
  end

  assign bus.phy_tx_dp  = tx_dp;
  assign bus.phy_tx_dn  = tx_dn;
  assign bus.phy_tx_en  = tx_en;
  assign bus.pkt_tx_gnt = gnt_q;

  assign ls_j_o        = ls_j_q;
  assign ls_k_o        = ls_k_q;
  assign ls_se0_o      = ls_se0_q;
  assign bus_reset_o   = (state_q == S_BUS_RST);
  assign suspended_o   = (state_q == S_SUSP) || (state_q == S_WAKE);
  assign evt_reset_o   = evt_reset_q;
  assign evt_suspend_o = evt_suspend_q;
  assign evt_resume_o  = evt_resume_q;

  a_gnt_wake_excl : assert property (@(posedge clk) disable iff (rst)
    !(gnt_q && (state_q == S_WAKE)));

endmodule

// File: tb/tb_usb_line_ctrl.sv
// Randomized and directed bench for usb_line_ctrl against a cycle-level
// behavioural model of the bus-state rules.
module tb_usb_line_ctrl;
  localparam int RST_DET = 8;
  localparam int SUSP_N  = 32;
  localparam int WAKE_N  = 16;

  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_SE0 = 2'b00;

  localparam int M_ACTIVE = 0;
  localparam int M_BUSRST = 1;
  localparam int M_SUSP   = 2;
  localparam int M_WAKE   = 3;
  localparam int M_RESUME = 4;

  logic clk = 1'b0;
  logic rst;
  logic wake_req;
  logic ls_j, ls_k, ls_se0, bus_reset, suspended;
  logic evt_reset, evt_suspend, evt_resume;

  always #5 clk = ~clk;

  usb_line_ctrl_if bus ();

  usb_line_ctrl #(
    .RST_DET_CYCLES(RST_DET),
    .SUSPEND_CYCLES(SUSP_N),
    .WAKE_CYCLES   (WAKE_N),
    .TIMER_W       (18)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .wake_req_i   (wake_req),
    .ls_j_o       (ls_j),
    .ls_k_o       (ls_k),
    .ls_se0_o     (ls_se0),
    .bus_reset_o  (bus_reset),
    .suspended_o  (suspended),
    .evt_reset_o  (evt_reset),
    .evt_suspend_o(evt_suspend),
    .evt_resume_o (evt_resume)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: bus state, last sampled raw line, run lengths.
  int         m_st;
  logic [1:0] m_prev;
  int         se0_len, idle_len, wake_left;
  bit         m_gnt, m_evr, m_evs, m_evm;

  // Running tallies of DUT activity, sampled once per cycle.
  int n_evr = 0, n_evs = 0, n_evm = 0, n_txk = 0, n_txen = 0, n_gnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = M_ACTIVE; m_prev = 2'b11;
    se0_len = 0; idle_len = 0; wake_left = 0;
    m_gnt = 0; m_evr = 0; m_evs = 0; m_evm = 0;
  endtask

  task automatic model_step();
    logic [1:0] raw;
    bit tx_now;
    int nst;
    raw    = {bus.phy_rx_dp, bus.phy_rx_dn};
    tx_now = m_gnt ? bus.pkt_tx_en : (m_st == M_WAKE);
    se0_len  = ((m_prev == LS_SE0) && !tx_now) ? se0_len + 1 : 0;
    idle_len = ((m_prev == LS_J) && !bus.phy_rx_chg && !tx_now && !m_gnt) ? idle_len + 1 : 0;
    nst = m_st; m_evr = 0; m_evs = 0; m_evm = 0;
    if (m_st != M_WAKE && se0_len == RST_DET) begin
      nst = M_BUSRST; m_evr = 1;
    end else begin
      case (m_st)
        M_BUSRST: if (m_prev != LS_SE0) nst = M_ACTIVE;
        M_ACTIVE: if (idle_len == SUSP_N) begin nst = M_SUSP; m_evs = 1; end
        M_SUSP: begin
          if (m_prev == LS_K) nst = M_RESUME;
          else if (wake_req && raw != LS_K) begin nst = M_WAKE; wake_left = WAKE_N; end
        end
        M_WAKE: begin
          wake_left--;
          if (wake_left == 0) nst = M_RESUME;
        end
        default: if (m_prev != LS_K) begin nst = M_ACTIVE; m_evm = 1; end
      endcase
    end
    m_gnt  = bus.pkt_tx_req && (nst == M_ACTIVE);
    m_st   = nst;
    m_prev = raw;
  endtask

  function automatic logic [11:0] dut_outs();
    return {ls_j, ls_k, ls_se0, bus_reset, suspended, evt_reset, evt_suspend, evt_resume,
            bus.pkt_tx_gnt, bus.phy_tx_dp, bus.phy_tx_dn, bus.phy_tx_en};
  endfunction

  function automatic logic [11:0] model_outs();
    logic [2:0] tx;
    if (m_gnt)              tx = {bus.pkt_tx_dp, bus.pkt_tx_dn, bus.pkt_tx_en};
    else if (m_st == M_WAKE) tx = 3'b011;
    else                    tx = 3'b000;
    return {m_prev == LS_J, m_prev == LS_K, m_prev == LS_SE0, m_st == M_BUSRST,
            (m_st == M_SUSP) || (m_st == M_WAKE), m_evr, m_evs, m_evm, m_gnt, tx};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
    chk("outputs", 32'(dut_outs()), 32'(model_outs()));
    n_evr  += int'(evt_reset);
    n_evs  += int'(evt_suspend);
    n_evm  += int'(evt_resume);
    n_txen += int'(bus.phy_tx_en);
    n_txk  += int'(bus.phy_tx_en && !bus.phy_tx_dp && bus.phy_tx_dn);
    n_gnt  += int'(bus.pkt_tx_gnt);
  endtask

  task automatic line(input logic [1:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      bus.phy_rx_chg = (i == 0) && ({bus.phy_rx_dp, bus.phy_rx_dn} != v);
      {bus.phy_rx_dp, bus.phy_rx_dn} = v;
      tick();
    end
    bus.phy_rx_chg = 1'b0;
  endtask

  task automatic go_susp();
    bus.pkt_tx_req = 1'b0;
    wake_req = 1'b0;
    line(LS_SE0, 2);
    line(LS_J, 60);
    chk("reach_susp", suspended, 1);
  endtask

  initial begin
    int base, r, n;
    logic [1:0] v;
    rst = 1'b1;
    wake_req = 1'b0;
    bus.phy_rx_dp = 1'b1; bus.phy_rx_dn = 1'b0; bus.phy_rx_chg = 1'b0;
    bus.pkt_tx_req = 1'b0; bus.pkt_tx_dp = 1'b0; bus.pkt_tx_dn = 1'b0; bus.pkt_tx_en = 1'b0;
    model_reset();
    tick(); tick();
    chk("reset_outs", 32'(dut_outs()), 0);
    rst = 1'b0;

    // Bus reset after 8 SE0 clocks, released by J without a resume event.
    line(LS_J, 4);
    base = n_evr;
    line(LS_SE0, 8);
    line(LS_J, 1);
    chk("busrst_level", bus_reset, 1);
    chk("busrst_pulses", n_evr - base, 1);
    base = n_evm;
    line(LS_J, 3);
    chk("busrst_exit", bus_reset, 0);
    chk("busrst_no_resume", n_evm - base, 0);

    // SE0 one clock short of the reset threshold.
    base = n_evr;
    line(LS_SE0, 7);
    line(LS_J, 3);
    chk("se0_short_pulses", n_evr - base, 0);
    chk("se0_short_level", bus_reset, 0);

    // Suspend needs exactly 32 idle J clocks.
    line(LS_SE0, 2);
    base = n_evs;
    line(LS_J, 32);
    chk("susp_before", suspended, 0);
    line(LS_J, 1);
    chk("susp_after", suspended, 1);
    chk("susp_pulses", n_evs - base, 1);

    // Remote wakeup: 16 clocks of driven K, then host resume.
    base = n_txk;
    wake_req = 1'b1;
    line(LS_J, 1);
    wake_req = 1'b0;
    chk("wake_suspended", suspended, 1);
    line(LS_K, 36);
    chk("wake_k_clocks", n_txk - base, WAKE_N);
    chk("wake_resume_state", suspended, 0);
    base = n_evm;
    line(LS_SE0, 2);
    line(LS_J, 3);
    chk("wake_resume_pulses", n_evm - base, 1);
    chk("wake_done", suspended, 0);

    // Host-initiated resume.
    go_susp();
    base = n_evm;
    line(LS_K, 5);
    chk("host_resume_state", suspended, 0);
    line(LS_J, 3);
    chk("host_resume_pulses", n_evm - base, 1);

    // Wakeup request in the same clock as the first host K.
    go_susp();
    base = n_txen;
    wake_req = 1'b1;
    line(LS_K, 1);
    wake_req = 1'b0;
    line(LS_K, 5);
    chk("k_beats_wake", n_txen - base, 0);
    line(LS_J, 3);

    // Arbitration and TX mux while ACTIVE.
    bus.pkt_tx_req = 1'b1;
    line(LS_J, 1);
    chk("gnt_rise", bus.pkt_tx_gnt, 1);
    for (int i = 0; i < 4; i++) begin
      {bus.pkt_tx_dp, bus.pkt_tx_dn, bus.pkt_tx_en} = 3'($urandom);
      line(LS_J, 1);
      chk("tx_mirror", {bus.phy_tx_dp, bus.phy_tx_dn, bus.phy_tx_en},
          {bus.pkt_tx_dp, bus.pkt_tx_dn, bus.pkt_tx_en});
    end
    bus.pkt_tx_en = 1'b0;
    base = n_evs;
    line(LS_J, 40);
    chk("gnt_no_suspend", n_evs - base, 0);
    chk("gnt_held", bus.pkt_tx_gnt, 1);
    bus.pkt_tx_req = 1'b0;
    line(LS_J, 1);
    chk("gnt_fall", bus.pkt_tx_gnt, 0);

    // No grant while suspended.
    go_susp();
    base = n_gnt;
    bus.pkt_tx_req = 1'b1;
    line(LS_J, 5);
    chk("no_gnt_susp", n_gnt - base, 0);
    bus.pkt_tx_req = 1'b0;

    // Randomized line activity, requests and wakeups.
    for (int b = 0; b < 160; b++) begin
      r = $urandom_range(0, 9);
      v = (r < 5) ? LS_J : (r < 7) ? LS_K : (r < 9) ? LS_SE0 : 2'b11;
      n = $urandom_range(1, 40);
      bus.pkt_tx_req = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < n; i++) begin
        bus.phy_rx_chg = ((i == 0) && ({bus.phy_rx_dp, bus.phy_rx_dn} != v)) ||
                         ($urandom_range(0, 63) == 0);
        {bus.phy_rx_dp, bus.phy_rx_dn} = v;
        {bus.pkt_tx_dp, bus.pkt_tx_dn, bus.pkt_tx_en} = 3'($urandom);
        wake_req = ($urandom_range(0, 15) == 0);
        tick();
      end
    end
    bus.phy_rx_chg = 1'b0;
    wake_req = 1'b0;

    // Asynchronous reset in the middle of a wakeup.
    go_susp();
    wake_req = 1'b1;
    line(LS_J, 1);
    wake_req = 1'b0;
    line(LS_K, 4);
    chk("wake_before_rst", bus.phy_tx_en, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_tx_en", bus.phy_tx_en, 0);
    chk("rst_all_outs", 32'(dut_outs()), 0);
    model_reset();
    tick();
    rst = 1'b0;
    line(LS_J, 3);
    chk("rst_active", {bus_reset, suspended, bus.phy_tx_en}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
